// File: rtl/sprite_compositor.sv
// Two-stage pixel compositor: background scene plus LAYER_NUM colour-keyed sprite layers,
// frame-shadowed layer enables and per-frame player collision flags.
module sprite_compositor #(
  parameter int                   LAYER_NUM = 16,
  parameter int                   COLOR_W   = 12,
  parameter logic [COLOR_W-1:0]   KEY_COLOR = '0,
  parameter logic [LAYER_NUM-1:0] EN_RESET  = '1
) (
  input  logic                         clk,
  input  logic                         clrn,
  input  logic                         pix_en,
  input  logic                         frame_start,
  input  logic [COLOR_W-1:0]           scene_rgb,
  input  logic [LAYER_NUM-1:0]         layer_hit,
  input  logic [LAYER_NUM*COLOR_W-1:0] layer_rgb,
  input  logic [LAYER_NUM-1:0]         layer_en_next,
  output logic [COLOR_W-1:0]           rgb_out,
  output logic                         rgb_valid,
  output logic [LAYER_NUM-1:0]         layer_en_active,
  output logic [LAYER_NUM-1:0]         collide_flags,
  output logic                         collide_any
);

  localparam int P = LAYER_NUM - 1;

  logic [LAYER_NUM-1:0]         eff_next;
  logic [LAYER_NUM-1:0]         eff1;
  logic [LAYER_NUM*COLOR_W-1:0] rgb1;
  logic [COLOR_W-1:0]           scene1;
  logic                         v1;
  logic [COLOR_W-1:0]           sel_rgb;
  logic [LAYER_NUM-1:0]         coll_term;
  logic [LAYER_NUM-1:0]         acc;

  always_comb begin
    eff_next = '0;
    for (int i = 0; i < LAYER_NUM; i++) begin
      eff_next[i] = layer_hit[i] & layer_en_active[i] &
                    (layer_rgb[i*COLOR_W +: COLOR_W] != KEY_COLOR);
    end
  end

  // Last-wins scan: the highest effective index overrides everything below it.
  always_comb begin
    sel_rgb = scene1;
    for (int i = 0; i < LAYER_NUM; i++) begin
      if (eff1[i]) sel_rgb = rgb1[i*COLOR_W +: COLOR_W];
    end
  end

  always_comb begin
    coll_term = '0;
    if (v1 && eff1[P]) coll_term = eff1;
    coll_term[P] = 1'b0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      layer_en_active <= EN_RESET;
    end else if (frame_start) begin
      layer_en_active <= layer_en_next;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      eff1      <= '0;
      rgb1      <= '0;
      scene1    <= '0;
      v1        <= 1'b0;
      rgb_out   <= '0;
      rgb_valid <= 1'b0;
    end else begin
      eff1      <= eff_next;
      rgb1      <= layer_rgb;
      scene1    <= scene_rgb;
      v1        <= pix_en;
      rgb_valid <= v1;
      if (v1) rgb_out <= sel_rgb;
    end
  end

  // A collision seen in the frame_start cycle seeds the new frame rather than the published one.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      acc           <= '0;
      collide_flags <= '0;
      collide_any   <= 1'b0;
    end else if (frame_start) begin
      acc           <= coll_term;
      collide_flags <= acc;
      collide_any   <= |acc;
    end else begin
      acc <= acc | coll_term;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed self-checking bench for sprite_compositor with four layers.
module tb_sprite_compositor;

  localparam int LN = 4;
  localparam int CW = 12;

  logic            clk;
  logic            clrn;
  logic            pix_en;
  logic            frame_start;
  logic [CW-1:0]   scene_rgb;
  logic [LN-1:0]   layer_hit;
  logic [LN*CW-1:0] layer_rgb;
  logic [LN-1:0]   layer_en_next;
  logic [CW-1:0]   rgb_out;
  logic            rgb_valid;
  logic [LN-1:0]   layer_en_active;
  logic [LN-1:0]   collide_flags;
  logic            collide_any;

  int checks = 0;
  int errors = 0;

  sprite_compositor #(
    .LAYER_NUM(LN),
    .COLOR_W(CW),
    .KEY_COLOR(12'h000),
    .EN_RESET(4'hF)
  ) dut (
    .clk(clk),
    .clrn(clrn),
    .pix_en(pix_en),
    .frame_start(frame_start),
    .scene_rgb(scene_rgb),
    .layer_hit(layer_hit),
    .layer_rgb(layer_rgb),
    .layer_en_next(layer_en_next),
    .rgb_out(rgb_out),
    .rgb_valid(rgb_valid),
    .layer_en_active(layer_en_active),
    .collide_flags(collide_flags),
    .collide_any(collide_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_rgb(input string name, input logic [CW-1:0] exp_rgb, input logic exp_valid);
    checks++;
    if (rgb_out !== exp_rgb || rgb_valid !== exp_valid) begin
      errors++;
      $display("[TB] FAIL %s: rgb_out=%h valid=%b, required rgb_out=%h valid=%b",
               name, rgb_out, rgb_valid, exp_rgb, exp_valid);
    end
  endtask

  task automatic check_flags(input string name, input logic [LN-1:0] exp_flags);
    checks++;
    if (collide_flags !== exp_flags || collide_any !== (|exp_flags)) begin
      errors++;
      $display("[TB] FAIL %s: collide_flags=%b any=%b, required flags=%b any=%b",
               name, collide_flags, collide_any, exp_flags, |exp_flags);
    end
  endtask

  task automatic check_en(input string name, input logic [LN-1:0] exp_en);
    checks++;
    if (layer_en_active !== exp_en) begin
      errors++;
      $display("[TB] FAIL %s: layer_en_active=%b, required %b", name, layer_en_active, exp_en);
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pix_en        = 1'($urandom);
      frame_start   = 1'($urandom);
      scene_rgb     = 12'($urandom);
      layer_hit     = 4'($urandom);
      layer_rgb     = {$urandom, $urandom};
      layer_en_next = 4'($urandom);
      tick();
    end
    check_rgb("reset_rgb", 12'h000, 1'b0);
    check_en("reset_en", 4'hF);
    check_flags("reset_flags", 4'b0000);
    frame_start   = 1'b0;
    scene_rgb     = 12'h000;
    layer_hit     = 4'b0000;
    layer_rgb     = '0;
    layer_en_next = 4'hF;
    pix_en        = 1'b1;
    clrn          = 1'b1;
    tick();
    check_rgb("reset_latency_c1", 12'h000, 1'b0);
    tick();
    check_rgb("reset_latency_c2", 12'h000, 1'b1);
  endtask

  task automatic test_priority();
    scene_rgb = 12'h0F0;
    layer_hit = 4'b0110;
    layer_rgb = {12'h333, 12'h222, 12'h111, 12'h555};
    tick(2);
    check_rgb("prio_top", 12'h222, 1'b1);
    layer_rgb = {12'h333, 12'h000, 12'h111, 12'h555};
    tick(2);
    check_rgb("prio_key_exposes", 12'h111, 1'b1);
    layer_hit = 4'b0000;
    tick(2);
    check_rgb("prio_scene", 12'h0F0, 1'b1);
  endtask

  task automatic test_shadow_enable();
    layer_en_next = 4'b1011;
    layer_hit     = 4'b0100;
    layer_rgb     = {12'h333, 12'h222, 12'h111, 12'h555};
    tick(2);
    check_rgb("shadow_midframe", 12'h222, 1'b1);
    check_en("shadow_midframe_en", 4'hF);
    pulse_frame();
    check_en("shadow_applied_en", 4'b1011);
    tick();
    check_rgb("shadow_old_en_at_fs", 12'h222, 1'b1);
    tick();
    check_rgb("shadow_new_en", 12'h0F0, 1'b1);
  endtask

  task automatic test_collision();
    layer_hit     = 4'b0000;
    layer_en_next = 4'hF;
    pulse_frame();
    tick(2);
    pulse_frame();
    check_flags("coll_clean_frame", 4'b0000);
    layer_hit = 4'b1010;
    layer_rgb = {12'h333, 12'h222, 12'h111, 12'h555};
    tick();
    layer_hit = 4'b0000;
    tick(2);
    pulse_frame();
    check_flags("coll_published", 4'b0010);
    tick(3);
    pulse_frame();
    check_flags("coll_cleared_next_frame", 4'b0000);
  endtask

  task automatic test_boundary();
    layer_hit = 4'b1001;
    tick();
    layer_hit = 4'b0000;
    pulse_frame();
    check_flags("bound_excluded", 4'b0000);
    tick(2);
    pulse_frame();
    check_flags("bound_next_frame", 4'b0001);
    tick(2);
    check_rgb("bound_scene_before_idle", 12'h0F0, 1'b1);
    pix_en    = 1'b0;
    layer_hit = 4'b1001;
    scene_rgb = 12'hABC;
    tick(3);
    check_rgb("bound_idle_holds", 12'h0F0, 1'b0);
    pix_en    = 1'b1;
    layer_hit = 4'b0000;
    scene_rgb = 12'h0F0;
    tick(2);
    pulse_frame();
    check_flags("bound_idle_not_flagged", 4'b0000);
  endtask

  task automatic test_midframe_reset();
    layer_en_next = 4'b1110;
    pulse_frame();
    check_en("rst_pre_en", 4'b1110);
    layer_hit = 4'b1100;
    tick();
    layer_hit = 4'b0000;
    tick(2);
    pulse_frame();
    check_flags("rst_pre_flags", 4'b0100);
    layer_hit = 4'b1100;
    tick();
    layer_hit = 4'b0000;
    tick();
    clrn = 1'b0;
    #1;
    check_flags("rst_async_flags", 4'b0000);
    check_en("rst_async_en", 4'hF);
    check_rgb("rst_async_rgb", 12'h000, 1'b0);
    pix_en = 1'b0;
    tick();
    clrn = 1'b1;
    tick(2);
    check_rgb("rst_no_inflight", 12'h000, 1'b0);
    pix_en = 1'b1;
    tick(2);
    pulse_frame();
    check_flags("rst_acc_empty", 4'b0000);
    check_rgb("rst_resume", 12'h0F0, 1'b1);
  endtask

  initial begin
    clrn          = 1'b0;
    pix_en        = 1'b0;
    frame_start   = 1'b0;
    scene_rgb     = '0;
    layer_hit     = '0;
    layer_rgb     = '0;
    layer_en_next = '1;
    test_reset();
    test_priority();
    test_shadow_enable();
    test_collision();
    test_boundary();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised, pipelined pixel compositor that replaces fixed-count, hand-wired sprite layering in the render path.
- Merges a background scene pixel with LAYER_NUM sprite layers by index priority, with a colour-key for transparency.
- Holds per-layer enables in shadow registers that update only at frame start.
- Accumulates per-frame collision flags between the player layer (top index) and every other layer, for use by game logic.

Parameters:
- LAYER_NUM, 16, number of sprite layers (2..32); layer LAYER_NUM-1 is the player layer and has top priority.
- COLOR_W, 12, pixel width ({r,g,b}, 4 bits each at default).
- KEY_COLOR, 12'h000, layer pixel value treated as transparent.
- EN_RESET, all ones, reset value of the active layer-enable register.

Ports:
- clk  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- pix_en  in  1  current inputs form a valid visible pixel.
- frame_start  in  1  one-cycle pulse at start of frame.
- scene_rgb  in  COLOR_W  background pixel.
- layer_hit  in  LAYER_NUM  per-layer coverage of current pixel.
- layer_rgb  in  LAYER_NUM*COLOR_W  per-layer colour; layer i occupies bits [i*COLOR_W +: COLOR_W].
- layer_en_next  in  LAYER_NUM  requested enables, applied at next frame_start.
- rgb_out  out  COLOR_W  composited pixel.
- rgb_valid  out  1  rgb_out carries a new pixel this cycle.
- layer_en_active  out  LAYER_NUM  enables currently in effect.
- collide_flags  out  LAYER_NUM  bit i = player overlapped layer i during the previous frame.
- collide_any  out  1  OR of collide_flags.

Behaviour:
- Single clock domain. clrn low asynchronously forces:
  - rgb_out=0, rgb_valid=0, collide_flags=0, collide_any=0;
  - layer_en_active=EN_RESET;
  - all pipeline registers and the collision accumulator to 0.
- Pipeline is free-running (no stall), latency exactly 2 clk.
- Stage 1 (registered):
  - eff[i] = layer_hit[i] & layer_en_active[i] & (layer_rgb_i != KEY_COLOR);
  - register eff, layer_rgb, scene_rgb and v1=pix_en.
- Stage 2 (registered):
  - if v1: rgb_out = layer_rgb of the highest i with eff[i]=1, else scene_rgb; rgb_valid <= 1.
  - if !v1: rgb_out holds its value; rgb_valid <= 0.
- Priority is strictly by index; a transparent pixel on a higher layer exposes the next lower effective layer or the scene.
- Enable shadowing:
  - On a cycle with frame_start=1, layer_en_active <= layer_en_next.
  - Otherwise it holds; layer_en_next changes mid-frame have no effect.
  - Stage 1 in the frame_start cycle uses the old enables; the new enables apply from the next cycle.
- Collision accumulator acc[LAYER_NUM-1:0]:
  - Evaluated on stage-1 registered data when v1=1 and eff[P]=1, where P=LAYER_NUM-1.
  - In that case, acc[i] |= eff[i] for i<P.
  - acc[P] and collide_flags[P] are always 0.
  - Pixels with v1=0 never set flags, even if hits are present.
- Frame boundary (frame_start=1):
  - collide_flags <= acc;
  - acc <= the collision term of the current cycle only. A hit coincident with frame_start belongs to the new frame and is not lost.
  - collide_any is registered and equals |collide_flags, i.e. it updates in the same cycle as collide_flags.
- Two frame_start pulses in consecutive cycles are legal; the second publishes an acc holding only the first cycle's term.
- LAYER_NUM parametrisation: no hard-wired layer count anywhere. The priority select is a loop or generate over index with last-wins semantics.
- Reset mid-frame: accumulator and published flags cleared, enables return to EN_RESET, in-flight pixels discarded (rgb_valid=0 until 2 cycles after the first post-reset pix_en).

Test Plan (LAYER_NUM=4, KEY_COLOR=12'h000, EN_RESET=4'hF):
1. Reset: hold clrn=0 with random inputs -> rgb_out=0, rgb_valid=0, layer_en_active=4'hF, collide_flags=0. Release clrn, pix_en=1 at cycle 0 -> rgb_valid first high at cycle 2.
2. Priority: scene=12'h0F0, hit=4'b0110, rgb1=12'h111, rgb2=12'h222, pix_en=1 -> rgb_out=12'h222 two cycles later. Set rgb2=12'h000 -> 12'h111. Set hit=0 -> 12'h0F0.
3. Shadow enable: layer_en_next=4'b1011 mid-frame with hit=4'b0100, rgb2=12'h222 -> rgb_out stays 12'h222. After a frame_start pulse -> layer_en_active=4'b1011 and rgb_out=scene from the following pixel.
4. Collision: in frame, one pixel with hit=4'b1010 and rgb≠0 -> after next frame_start, collide_flags=4'b0010, collide_any=1. Following frame with no overlap -> flags return to 0 at the next frame_start.
5. Boundary: overlap pixel hit=4'b1001 coincident with frame_start at stage 1 -> published flags exclude it; flags=4'b0001 after the subsequent frame_start. Overlap with pix_en=0 -> never flagged.
6. Mid-operation reset: clrn pulsed low mid-frame after overlap -> collide_flags=0, acc empty; next frame_start publishes 0.
